// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT result queue between the 8-bit ALU and its consumer.
// Captures {op, overflow, carry, zero, y} and hands entries out over valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_ready = !full
//   in_y/carry/overflow/zero/op   ALU result to enqueue
//   out_valid/out_ready consumer handshake; out_valid = !empty
//   out_y/carry/overflow/zero/op  head entry, forced to 0 while empty
//   count, full, empty  occupancy status
// Optional (ALU_STICKY_FLAGS_EN):
//   sticky_clr, sticky_carry, sticky_overflow  accumulated flags since clear
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_y,
  input  logic          in_carry,
  input  logic          in_overflow,
  input  logic          in_zero,
  input  logic [2:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_y,
  output logic          out_carry,
  output logic          out_overflow,
  output logic          out_zero,
  output logic [2:0]    out_op,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic          sticky_clr,
  output logic          sticky_carry,
  output logic          sticky_overflow
`endif
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [13:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [13:0]   w_wdata;
  logic [13:0]   w_head;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  // Entry layout: {op[13:11], overflow[10], carry[9], zero[8], y[7:0]}
  assign w_wdata = {in_op, in_overflow, in_carry, in_zero, in_y};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= w_wdata;
  end

  assign w_head = w_empty ? 14'd0 : r_mem[r_rptr];

  assign in_ready     = ~w_full;
  assign out_valid    = ~w_empty;
  assign out_y        = w_head[7:0];
  assign out_zero     = w_head[8];
  assign out_carry    = w_head[9];
  assign out_overflow = w_head[10];
  assign out_op       = w_head[13:11];
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;

`ifdef ALU_STICKY_FLAGS_EN
  logic r_sticky_carry;
  logic r_sticky_overflow;

  // A flagged push in the clear cycle keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_carry    <= 1'b0;
      r_sticky_overflow <= 1'b0;
    end else begin
      if (w_push && in_carry)
        r_sticky_carry <= 1'b1;
      else if (sticky_clr)
        r_sticky_carry <= 1'b0;
      if (w_push && in_overflow)
        r_sticky_overflow <= 1'b1;
      else if (sticky_clr)
        r_sticky_overflow <= 1'b0;
    end
  end

  assign sticky_carry    = r_sticky_carry;
  assign sticky_overflow = r_sticky_overflow;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed self-checking bench for alu_result_fifo.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_y;
  logic       in_carry;
  logic       in_overflow;
  logic       in_zero;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_carry;
  logic       out_overflow;
  logic       out_zero;
  logic [2:0] out_op;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef ALU_STICKY_FLAGS_EN
  logic       sticky_clr;
  logic       sticky_carry;
  logic       sticky_overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_zero      (in_zero),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_op       (out_op),
    .count        (count),
    .full         (full),
    .empty        (empty)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr      (sticky_clr),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] y,
                       input logic c, input logic o,
                       input logic z, input logic [2:0] op);
    in_valid    = v;
    in_y        = y;
    in_carry    = c;
    in_overflow = o;
    in_zero     = z;
    in_op       = op;
  endtask

  initial begin
    logic [7:0] exp_y;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_flags", 32'({out_carry, out_overflow, out_zero}), 32'd0);
    chk("rst_op", 32'(out_op), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    // first push, consumer stalled; no same-cycle bypass
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 3'b000);
    chk("nobypass_valid", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_y", 32'(out_y), 32'h00);
    chk("p1_carry", 32'(out_carry), 32'd1);
    chk("p1_ovf", 32'(out_overflow), 32'd0);
    chk("p1_zero", 32'(out_zero), 32'd1);
    chk("p1_op", 32'(out_op), 32'd0);
    chk("p1_count", 32'(count), 32'd1);
    tick();
    tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_carry", 32'(out_carry), 32'd1);
    chk("stall_zero", 32'(out_zero), 32'd1);
    chk("stall_count", 32'(count), 32'd1);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain1_empty", 32'(empty), 32'd1);

    // fill to DEPTH with 01..04, op tagged with index
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 3'(i));
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_head_y", 32'(out_y), 32'h01);
    chk("fill_head_op", 32'(out_op), 32'd1);
    chk("fill_head_ovf", 32'(out_overflow), 32'd1);

    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 3'd5);
    tick();
    chk("over_count", 32'(count), 32'd4);
    chk("over_head", 32'(out_y), 32'h01);

    // full with push+pop: pop completes, push refused
    drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 3'd6);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    out_ready = 1'b0;
    chk("fullpp_count", 32'(count), 32'd3);
    chk("fullpp_in_ready", 32'(in_ready), 32'd1);
    chk("fullpp_head", 32'(out_y), 32'h02);

    out_ready = 1'b1;
    chk("drain_02", 32'(out_y), 32'h02);
    tick();
    chk("drain_03", 32'(out_y), 32'h03);
    tick();
    chk("drain_04", 32'(out_y), 32'h04);
    chk("drain_op4", 32'(out_op), 32'd4);
    tick();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_y0", 32'(out_y), 32'd0);
    chk("drain_ovf0", 32'(out_overflow), 32'd0);

    // pop on empty is ignored
    tick();
    chk("emptypop_count", 32'(count), 32'd0);

    // push+pop on empty: push accepted
    drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 3'd2);
    tick();
    out_ready = 1'b0;
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_head", 32'(out_y), 32'h10);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 3'd3);
    tick();
    chk("two_count", 32'(count), 32'd2);

    // 8 cycles of simultaneous push/pop across pointer wrap
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, 1'b0, 3'd1);
      exp_y = (k < 2) ? 8'(8'h10 + k) : 8'(8'h20 + k - 2);
      chk($sformatf("pp_head%0d", k), 32'(out_y), 32'(exp_y));
      tick();
      chk($sformatf("pp_count%0d", k), 32'(count), 32'd2);
    end
    out_ready = 1'b0;
    drive(1'b1, 8'h28, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("pp_after_head", 32'(out_y), 32'h26);
    tick();
    chk("three_count", 32'(count), 32'd3);

    // reset mid-operation, with a push that must be dropped
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 3'd7);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_y", 32'(out_y), 32'd0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd5);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("mrst_a5_y", 32'(out_y), 32'hA5);
    chk("mrst_a5_valid", 32'(out_valid), 32'd1);
    chk("mrst_a5_count", 32'(count), 32'd1);
    chk("mrst_a5_op", 32'(out_op), 32'd5);

`ifdef ALU_STICKY_FLAGS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st_rst_ovf", 32'(sticky_overflow), 32'd0);
    chk("st_rst_carry", 32'(sticky_carry), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    chk("st_set_ovf", 32'(sticky_overflow), 32'd1);
    chk("st_set_carry", 32'(sticky_carry), 32'd0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 3'd0);
    sticky_clr = 1'b1;
    tick();
    chk("st_clr_ovf", 32'(sticky_overflow), 32'd0);
    drive(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    chk("st_win_ovf", 32'(sticky_overflow), 32'd1);
    chk("st_win_carry", 32'(sticky_carry), 32'd1);
    sticky_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk("st_hold_ovf", 32'(sticky_overflow), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
